// File: rtl/rr_mux_arbiter.sv
// rr_mux_arbiter
//   Round-robin arbiter and select controller for an N:1 mux datapath.
//   N requesters compete for one W-bit output lane. The block picks the
//   owner with a rotating-priority scan, registers the one-hot grant and the
//   mux select, and steers the owner's lane to data_out.
//
//   Optional feature (macro RR_ARB_HOLD_LIMIT_EN): an owner that has held the
//   lane for MAX_HOLD consecutive cycles is preempted when someone else waits.
//   With the macro undefined the owner keeps the lane until it drops req.
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   req       [N-1:0]    level-sensitive requests
//   data_in   [N*W-1:0]  lane i is bits [i*W +: W]
//   gnt       [N-1:0]    registered one-hot grant, zero when idle
//   sel       [$clog2(N)-1:0] registered select, index of the current owner
//   valid     registered, high while a grant is active
//   data_out  [W-1:0]    lane[sel] when valid, else zero
module rr_mux_arbiter #(
  parameter int N        = 8,
  parameter int W        = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N-1:0]                 req,
  input  logic [N*W-1:0]               data_in,
  output logic [N-1:0]                 gnt,
  output logic [$clog2(N)-1:0]         sel,
  output logic                         valid,
  output logic [W-1:0]                 data_out
);

  localparam int SW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state_reg, state_next;
  logic [SW-1:0] sel_reg, sel_next;
  logic [SW-1:0] ptr_reg, ptr_next;
  logic [N-1:0]  gnt_reg, gnt_next;
  logic          valid_reg, valid_next;

`ifdef RR_ARB_HOLD_LIMIT_EN
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);
  logic [HW-1:0] hold_cnt_reg, hold_cnt_next;
`endif

  // Candidates for a new grant never include the current owner: on release
  // its req bit is already zero, and on preemption it must be skipped. In
  // IDLE gnt_reg is zero so the mask is transparent.
  logic [N-1:0]  arb_req;
  logic [N-1:0]  rot_req;
  logic [SW-1:0] offset;
  logic          found;
  logic [SW-1:0] winner;

  assign arb_req = req & ~gnt_reg;
  assign found   = |arb_req;

  // Rotate so that bit 0 is the requester at ptr; N is a power of two, so
  // the index wraps for free in SW bits.
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_rot
      localparam logic [SW-1:0] OFF = SW'(gi);
      assign rot_req[gi] = arb_req[ptr_reg + OFF];
    end
  endgenerate

  // Lowest set bit of the rotated vector is the first requester at or after ptr.
  always_comb begin
    offset = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rot_req[k]) offset = SW'(k);
    end
  end

  assign winner = ptr_reg + offset;

  // Next-state and register updates.
  always_comb begin
    state_next = state_reg;
    sel_next   = sel_reg;
    ptr_next   = ptr_reg;
    gnt_next   = gnt_reg;
    valid_next = valid_reg;
`ifdef RR_ARB_HOLD_LIMIT_EN
    hold_cnt_next = hold_cnt_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (found) begin
          state_next = GRANT;
          sel_next   = winner;
          gnt_next   = {{(N-1){1'b0}}, 1'b1} << winner;
          valid_next = 1'b1;
          ptr_next   = winner + SW'(1);
`ifdef RR_ARB_HOLD_LIMIT_EN
          hold_cnt_next = '0;
`endif
        end
      end
      GRANT: begin
        if (!req[sel_reg]) begin
          if (found) begin
            // zero-bubble handover
            sel_next   = winner;
            gnt_next   = {{(N-1){1'b0}}, 1'b1} << winner;
            ptr_next   = winner + SW'(1);
`ifdef RR_ARB_HOLD_LIMIT_EN
            hold_cnt_next = '0;
`endif
          end else begin
            state_next = IDLE;
            gnt_next   = '0;
            valid_next = 1'b0;
          end
        end else begin
`ifdef RR_ARB_HOLD_LIMIT_EN
          if (hold_cnt_reg == HOLD_LAST) begin
            if (found) begin
              // owner used up its tenure and someone else waits
              sel_next      = winner;
              gnt_next      = {{(N-1){1'b0}}, 1'b1} << winner;
              ptr_next      = winner + SW'(1);
              hold_cnt_next = '0;
            end
          end else begin
            hold_cnt_next = hold_cnt_reg + HW'(1);
          end
`endif
        end
      end
      default: begin
        state_next = IDLE;
        gnt_next   = '0;
        valid_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      sel_reg   <= '0;
      ptr_reg   <= '0;
      gnt_reg   <= '0;
      valid_reg <= 1'b0;
`ifdef RR_ARB_HOLD_LIMIT_EN
      hold_cnt_reg <= '0;
`endif
    end else begin
      state_reg <= state_next;
      sel_reg   <= sel_next;
      ptr_reg   <= ptr_next;
      gnt_reg   <= gnt_next;
      valid_reg <= valid_next;
`ifdef RR_ARB_HOLD_LIMIT_EN
      hold_cnt_reg <= hold_cnt_next;
`endif
    end
  end

  // Output lane mux driven only by registered select/valid.
  logic [W-1:0] lanes [N];
  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_lane
      assign lanes[gi] = data_in[gi*W +: W];
    end
  endgenerate

  assign gnt      = gnt_reg;
  assign sel      = sel_reg;
  assign valid    = valid_reg;
  assign data_out = valid_reg ? lanes[sel_reg] : '0;

endmodule
